// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if
//   Groups the Avalon-MM read-master signals and the ready/valid sample
//   stream of rom_stream_reader.
//   master : the reader side (drives m_*, src_data/src_valid; takes
//            m_readdata, src_ready)
//   slave  : the environment side (memory slave + stream sink)
//   Parameters ADDR_W / DATA_W must match the reader instance.
interface rom_stream_reader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic              m_clken;
  logic [DATA_W-1:0] m_readdata;
  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_ready;

  modport master (
    output m_address, m_chipselect, m_write, m_clken,
    input  m_readdata,
    output src_data, src_valid,
    input  src_ready
  );

  modport slave (
    input  m_address, m_chipselect, m_write, m_clken,
    output m_readdata,
    input  src_data, src_valid,
    output src_ready
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Avalon-MM read master that drains a contiguous word range from a
//   fixed-latency ROM/RAM slave and presents the words as a ready/valid
//   stream. Reads are issued back-to-back under FIFO credit control;
//   a one-cycle done pulse marks completion.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   start, stop    : begin transfer (IDLE only) / abort (any non-IDLE state)
//   base_addr      : first word address, sampled on accepted start
//   word_count     : number of words 0..2^ADDR_W, sampled on accepted start
//   loop           : restart at base_addr after the last word
//                    (only when ROM_STREAM_LOOP_EN is defined)
//   busy, done     : not-IDLE status / one-cycle completion pulse
//   bus            : rom_stream_reader_if.master (Avalon-MM + stream)
// Build option: `define ROM_STREAM_LOOP_EN adds the loop port/behaviour.
module rom_stream_reader #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
`ifdef ROM_STREAM_LOOP_EN
  input  logic                loop,
`endif
  output logic                busy,
  output logic                done,
  rom_stream_reader_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t                  state, state_nx;
  logic [ADDR_W-1:0]       base_q;
  logic [ADDR_W:0]         count_q, issued_q, issued_nx;
  logic [READ_LATENCY-1:0] infl_q;
  logic [CW-1:0]           inflight;
  logic [CW:0]             occupancy;
  logic                    credit, strobe, tap, push, pop;
  logic                    fifo_clear, load, done_nx;

  logic [DATA_W-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           fifo_count_q;

  // Credit uses registered occupancy plus reads still in flight; a pop in
  // the same cycle is not counted, so a push can never land on a full FIFO.
  assign inflight  = CW'($countones(infl_q));
  assign occupancy = {1'b0, fifo_count_q} + {1'b0, inflight};
  assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);
  assign tap       = infl_q[READ_LATENCY-1];
  assign push      = tap && (state != S_FLUSH);
  assign pop       = bus.src_valid && bus.src_ready;

  assign busy             = (state != S_IDLE);
  assign bus.m_chipselect = strobe;
  assign bus.m_address    = base_q + issued_q[ADDR_W-1:0];
  assign bus.m_write      = 1'b0;
  assign bus.m_clken      = 1'b1;
  assign bus.src_valid    = (fifo_count_q != '0);
  assign bus.src_data     = bus.src_valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    state_nx   = state;
    issued_nx  = issued_q;
    strobe     = 1'b0;
    fifo_clear = 1'b0;
    load       = 1'b0;
    done_nx    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          if (word_count == '0) begin
            done_nx = 1'b1;
          end else begin
            load      = 1'b1;
            issued_nx = '0;
            state_nx  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          fifo_clear = 1'b1;
          state_nx   = S_FLUSH;
        end else if (credit) begin
          strobe = 1'b1;
          if (issued_q + (ADDR_W+1)'(1) == count_q) begin
`ifdef ROM_STREAM_LOOP_EN
            if (loop) begin
              issued_nx = '0;
            end else begin
              issued_nx = count_q;
              state_nx  = S_DRAIN;
            end
`else
            issued_nx = count_q;
            state_nx  = S_DRAIN;
`endif
          end else begin
            issued_nx = issued_q + (ADDR_W+1)'(1);
          end
        end
      end
      S_DRAIN: begin
        if (stop) begin
          fifo_clear = 1'b1;
          state_nx   = S_FLUSH;
        end else if (inflight == '0 &&
                     (fifo_count_q == '0 || (fifo_count_q == CW'(1) && pop))) begin
          // Leave on the edge that empties the FIFO so that done (registered)
          // and the falling busy appear in the same cycle.
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (inflight == '0) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      infl_q   <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      issued_q <= issued_nx;
      infl_q   <= (infl_q << 1) | READ_LATENCY'(strobe);
      done     <= done_nx;
      if (load) begin
        base_q  <= base_addr;
        count_q <= word_count;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else if (fifo_clear) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CW'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CW'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !fifo_clear) mem[wr_ptr_q] <= bus.m_readdata;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !fifo_clear && fifo_count_q == FULL));

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader
//   Directed bench for rom_stream_reader (ADDR_W=9, DATA_W=32, FIFO_DEPTH=8,
//   READ_LATENCY=1) against a 512-word slave model with mem[a]=a.
module tb_rom_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  word_count = '0;
  logic        busy, done;
  logic        ready = 1'b1;
`ifdef ROM_STREAM_LOOP_EN
  logic        loop_in = 1'b0;
`endif

  rom_stream_reader_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  rom_stream_reader #(.ADDR_W(9), .DATA_W(32), .FIFO_DEPTH(8), .READ_LATENCY(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .base_addr  (base_addr),
    .word_count (word_count),
`ifdef ROM_STREAM_LOOP_EN
    .loop       (loop_in),
`endif
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: one-cycle read latency, mem[a] = a.
  logic [31:0] rd_q = '0;
  always @(posedge clk) if (bus.m_chipselect) rd_q <= {23'd0, bus.m_address};
  assign bus.m_readdata = rd_q;
  assign bus.src_ready  = ready;

  // Monitor, sampled on the falling edge.
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [8:0]  addrs[$];
  int          done_cnt, done_cyc, outstanding, max_out, hold_viol;
  logic        done_busy, busy_seen, hold_prev;
  logic [31:0] hold_data;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.m_chipselect) addrs.push_back(bus.m_address);
      if (bus.src_valid && ready) begin
        got.push_back(bus.src_data);
        got_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      if (busy) busy_seen = 1'b1;
      if (outstanding + int'(bus.m_chipselect) > max_out)
        max_out = outstanding + int'(bus.m_chipselect);
      outstanding += int'(bus.m_chipselect) - int'(bus.src_valid && ready);
      if (hold_prev && !(bus.src_valid && bus.src_data === hold_data)) hold_viol++;
      hold_prev = bus.src_valid && !ready;
      hold_data = bus.src_data;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got.delete(); got_cyc.delete(); addrs.delete();
    done_cnt = 0; done_cyc = -1; done_busy = 1'b1; busy_seen = 1'b0;
    outstanding = 0; max_out = 0; hold_viol = 0; hold_prev = 1'b0;
  endtask

  // Drives start for one cycle; c0 is the cycle in which start is high.
  task automatic do_start(input logic [8:0] b, input logic [9:0] n, output int c0);
    @(posedge clk); #1;
    base_addr = b; word_count = n; start = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clk); n++;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int c0, bad;
    clear_mon();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cs", bus.m_chipselect, 0);
    chk("rst_addr", bus.m_address, 0);
    chk("rst_valid", bus.src_valid, 0);
    chk("rst_data", bus.src_data, 0);
    chk("rst_write", bus.m_write, 0);
    chk("rst_clken", bus.m_clken, 1);
    @(posedge clk); #1 reset_n = 1'b1;

    // 1: base 0x010, count 16, sink always ready
    clear_mon();
    ready = 1'b1;
    do_start(9'h010, 10'd16, c0);
    wait_done(60);
    chk("t1_len", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("t1_data", got[i], 32'h10 + i);
    bad = 0;
    for (int i = 0; i < got_cyc.size(); i++) if (got_cyc[i] != c0 + 3 + i) bad++;
    chk("t1_timing", bad, 0);
    chk("t1_first_valid", got_cyc.size() > 0 ? got_cyc[0] - c0 : -1, 3);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_cyc", done_cyc - c0, 19);
    chk("t1_done_busy", done_busy, 0);

    // 2: address wrap
    clear_mon();
    do_start(9'h1FE, 10'd4, c0);
    wait_done(40);
    chk("t2_nstrobe", addrs.size(), 4);
    for (int i = 0; i < 4 && i < addrs.size(); i++) chk("t2_addr", addrs[i], (9'h1FE + i) & 9'h1FF);
    chk("t2_len", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t2_data", got[i], (32'h1FE + i) & 32'h1FF);
    chk("t2_done_cnt", done_cnt, 1);

    // 3: count 32, sink ready about one cycle in three
    clear_mon();
    ready = 1'b0;
    do_start(9'h040, 10'd32, c0);
    for (int n = 0; n < 800 && done_cnt == 0; n++) begin
      @(posedge clk); #1 ready = ($urandom_range(0, 2) == 0);
    end
    ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_len", got.size(), 32);
    bad = 0;
    for (int i = 0; i < got.size(); i++) if (got[i] !== 32'h40 + i) bad++;
    chk("t3_order", bad, 0);
    chk("t3_credit", max_out <= 8, 1);
    chk("t3_hold", hold_viol, 0);
    chk("t3_done_cnt", done_cnt, 1);

    // 4: stop mid-RUN with the FIFO half full
    clear_mon();
    ready = 1'b0;
    do_start(9'h080, 10'd32, c0);
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(negedge clk);
    chk("t4_valid_before", bus.src_valid, 1);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("t4_valid_after", bus.src_valid, 0);
    chk("t4_nstrobe", addrs.size(), 5);
    @(negedge clk);
    chk("t4_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("t4_nstrobe_late", addrs.size(), 5);
    chk("t4_no_done", done_cnt, 0);
    clear_mon();
    ready = 1'b1;
    do_start(9'h100, 10'd2, c0);
    wait_done(30);
    chk("t4_restart_len", got.size(), 2);
    for (int i = 0; i < 2 && i < got.size(); i++) chk("t4_restart_data", got[i], 32'h100 + i);
    chk("t4_restart_done", done_cnt, 1);

    // 5a: count 0
    clear_mon();
    do_start(9'h055, 10'd0, c0);
    @(negedge clk);
    chk("t5_done_pulse", done, 1);
    chk("t5_busy", busy, 0);
    @(negedge clk);
    chk("t5_done_low", done, 0);
    chk("t5_nstrobe", addrs.size(), 0);

    // 5b: start and stop together in IDLE
    clear_mon();
    stop = 1'b1;
    do_start(9'h020, 10'd4, c0);
    stop = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_ss_busy", busy_seen, 0);
    chk("t5_ss_strobe", addrs.size(), 0);
    chk("t5_ss_done", done_cnt, 0);

    // 5c: reset mid-transfer
    clear_mon();
    do_start(9'h000, 10'd32, c0);
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_cs", bus.m_chipselect, 0);
    chk("t5_rst_addr", bus.m_address, 0);
    chk("t5_rst_valid", bus.src_valid, 0);
    chk("t5_rst_data", bus.src_data, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_rst_no_done", done_cnt, 0);
    chk("t5_rst_idle", busy, 0);

`ifdef ROM_STREAM_LOOP_EN
    // 6: loop over base 5, count 3
    clear_mon();
    loop_in = 1'b1;
    do_start(9'd5, 10'd3, c0);
    repeat (16) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 12; i++)
      if (i >= got.size() || got[i] !== 32'd5 + (i % 3) || got_cyc[i] != c0 + 3 + i) bad++;
    chk("t6_loop_stream", bad, 0);
    chk("t6_no_done_loop", done_cnt, 0);
    @(posedge clk); #1 loop_in = 1'b0;
    wait_done(40);
    chk("t6_done", done_cnt, 1);
    chk("t6_whole_pass", got.size() % 3, 0);
    chk("t6_last", got.size() > 0 ? got[got.size()-1] : 32'hFFFF_FFFF, 7);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Avalon-MM read master that drains a contiguous word range from the on-chip ROM/RAM slave (`mysystem_rom`, fixed read latency) and presents the words as a ready/valid sample stream toward the audio path. Software or a controller loads a base address and word count, then pulses start. The block issues back-to-back reads under FIFO credit control and signals completion with a one-cycle done pulse.

## Interface
- ADDR_W, 9, word address width; matches the slave's 512-word depth
- DATA_W, 32, data width
- FIFO_DEPTH, 8, output FIFO entries; power of 2, ≥ 4
- READ_LATENCY, 1, slave read latency in cycles; legal values 1 or 2

- clk  in  1  system clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a transfer; honoured only in IDLE
- stop  in  1  abort request; honoured in any non-IDLE state
- base_addr  in  ADDR_W  first word address, sampled on an accepted start
- word_count  in  ADDR_W+1  number of words, 0..2^ADDR_W, sampled on an accepted start
- loop  in  1  restart at base_addr after the last word; present only with ROM_STREAM_LOOP_EN
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- m_address  out  ADDR_W  read address
- m_chipselect  out  1  read strobe; m_write is tied low
- m_write  out  1  constant 0
- m_clken  out  1  constant 1
- m_readdata  in  DATA_W  valid READ_LATENCY cycles after the strobe
- src_data  out  DATA_W  stream data (FIFO head)
- src_valid  out  1  src_data valid
- src_ready  in  1  sink accepts when src_valid and src_ready are both high

## Operation
- States:
  - IDLE: an accepted start with word_count=0 pulses done the next cycle and stays in IDLE.
  - IDLE → RUN: an accepted start with word_count≠0. base_addr and word_count are latched, and the issue counter is cleared.
  - RUN: in any cycle where fifo_count + inflight < FIFO_DEPTH, assert m_chipselect with m_address = base + issued, then increment issued.
    - fifo_count is the registered occupancy; a same-cycle pop gives no credit.
  - RUN → DRAIN: when issued reaches count.
  - DRAIN → IDLE: when inflight=0 and the FIFO is empty; pulse done on the transition.
  - Any non-IDLE state → FLUSH on stop. FLUSH stops issuing, drops src_valid, clears the FIFO, and discards returning read data.
  - FLUSH → IDLE: when inflight=0. No done pulse is produced.
- inflight: READ_LATENCY-deep shift register of strobe flags. At the tap, m_readdata is pushed into the FIFO, except in FLUSH.
- Address arithmetic wraps modulo 2^ADDR_W (base 510, count 4 reads 510, 511, 0, 1).
- start while busy is ignored. start and stop in the same cycle: stop wins; in IDLE both are ignored.
- The FIFO never overflows by construction. A push to a full FIFO is a design error and is flagged by an assertion.
- Reset values: busy=0, done=0, m_chipselect=0, m_address=0, src_valid=0, src_data=0, FIFO empty, state IDLE. Reset mid-transfer discards everything; no done pulse.

## Timing
- start accepted in cycle 0:
  - RUN in cycle 1, first strobe in cycle 1
  - data captured into the FIFO in cycle 1+READ_LATENCY
  - src_valid high in cycle 2+READ_LATENCY (registered FIFO output)
- Throughput is 1 word/cycle sustained while src_ready is held high, given FIFO_DEPTH ≥ READ_LATENCY+3.
- done goes high the cycle after the pop that empties the FIFO in DRAIN. busy falls in the same cycle done is high.
- src_data/src_valid hold stable while src_valid=1 and src_ready=0.

## Configuration
- ROM_STREAM_LOOP_EN defined:
  - The loop port exists.
  - If loop=1 when issued reaches count, issued resets to 0 and RUN continues seamlessly. There is no bubble beyond credit limits and no done pulse.
  - Deasserting loop lets the current pass finish normally.
  - stop is the only exit while loop=1.
- Not defined:
  - The loop port is absent.
  - Every transfer ends with DRAIN → done.

## Test plan
- Base 0x010, count 16, src_ready=1, slave preloaded with mem[a]=a: stream 0x10..0x1F in order, one per cycle, done pulse exactly once, first src_valid 3 cycles after start (READ_LATENCY=1).
- Base 0x1FE, count 4: addresses 0x1FE, 0x1FF, 0x000, 0x001; data matches; done once.
- Count 32 with src_ready toggled 1-of-3 randomly: no loss, no duplication, no FIFO overflow assertion; in-flight strobes never exceed free FIFO entries.
- stop asserted mid-RUN with the FIFO half full: src_valid low next cycle, no further strobes, busy low within READ_LATENCY+1 cycles, no done; a following start for count 2 streams exactly 2 fresh words.
- start with count 0: done pulse next cycle, no strobe. start+stop in the same cycle from IDLE: nothing happens. reset_n low mid-transfer: all outputs at reset values immediately.
- ROM_STREAM_LOOP_EN, loop=1, base 5, count 3: stream 5, 6, 7, 5, 6, 7… with no gaps at src_ready=1. Drop loop: the current pass completes and done fires.
